// File: rtl/mccoy_core_p.sv
// Parametrised McCoy accumulator core: FETCH/EXEC FSM with a valid/ready instruction port, 2 cycles per instruction.
// Optional carry flag, carry_out port and BCS opcode (replacing AND) are enabled with `define MCCOY_CARRY_EN.
module mccoy_core_p #(
    parameter int DATA_W = 6,
    parameter int PC_W   = 6,
    parameter int NREGS  = 8,
    localparam int ARG_W = $clog2(NREGS),
    localparam int IW    = 3 + ARG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              zero_out
`ifdef MCCOY_CARRY_EN
    ,
    output logic              carry_out
`endif
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] EXEC  = 1'b1;

    localparam logic [2:0] OP_LD  = 3'b000;
    localparam logic [2:0] OP_ST  = 3'b001;
    localparam logic [2:0] OP_LI  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_BEZ = 3'b101;
    localparam logic [2:0] OP_JA  = 3'b110;
    localparam logic [2:0] OP_X7  = 3'b111;

    logic [0:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [2:0]        op;
    logic [ARG_W-1:0]  arg;
    logic [DATA_W-1:0] rv;
    logic [DATA_W-1:0] simm;

    // Zero-extend (DATA_W < PC_W) or truncate a data word into a PC value.
    function automatic logic [PC_W-1:0] to_pc(input logic [DATA_W-1:0] v);
        logic [DATA_W+PC_W-1:0] ext;
        ext = {{PC_W{1'b0}}, v};
        return ext[PC_W-1:0];
    endfunction

    assign op   = ir_q[2:0];
    assign arg  = ir_q[3 +: ARG_W];
    assign rv   = regs_q[arg];
    assign simm = DATA_W'($signed(arg));

`ifdef MCCOY_CARRY_EN
    logic              carry_q, carry_d;
    logic [DATA_W:0]   sum_w, diff_w;
    assign sum_w  = {1'b0, acc_q} + {1'b0, rv};
    assign diff_w = {1'b0, acc_q} - {1'b0, rv};
    assign carry_out = carry_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
`ifdef MCCOY_CARRY_EN
        carry_d = carry_q;
`endif
        if (state_q == FETCH) begin
            if (instr_valid) begin
                ir_d    = instr;
                state_d = EXEC;
            end
        end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
            case (op)
                OP_LD:  acc_d = rv;
                OP_ST:  regs_d[arg] = acc_q;
                OP_LI:  acc_d = simm;
`ifdef MCCOY_CARRY_EN
                OP_ADD: begin
                    acc_d   = sum_w[DATA_W-1:0];
                    carry_d = sum_w[DATA_W];
                end
                OP_SUB: begin
                    acc_d   = diff_w[DATA_W-1:0];
                    carry_d = ~diff_w[DATA_W];
                end
`else
                OP_ADD: acc_d = acc_q + rv;
                OP_SUB: acc_d = acc_q - rv;
`endif
                OP_BEZ: if (acc_q == '0) pc_d = to_pc(rv);
                OP_JA:  pc_d = to_pc(acc_q);
`ifdef MCCOY_CARRY_EN
                OP_X7:  if (carry_q) pc_d = to_pc(rv);
`else
                OP_X7:  acc_d = acc_q & rv;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef MCCOY_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            regs_q  <= regs_d;
`ifdef MCCOY_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign instr_ready = (state_q == FETCH);
    assign pc_out      = pc_q;
    assign acc_out     = acc_q;
    assign zero_out    = (acc_q == '0);

endmodule

// File: tb/tb_mccoy_core_p.sv
// Directed bench for mccoy_core_p (DATA_W=6, PC_W=6, NREGS=8).
// Carry checks are compiled in when MCCOY_CARRY_EN is defined.
module tb_mccoy_core_p;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [5:0] pc_out;
    logic [5:0] acc_out;
    logic       zero_out;
`ifdef MCCOY_CARRY_EN
    logic       carry_out;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    mccoy_core_p #(.DATA_W(6), .PC_W(6), .NREGS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .acc_out     (acc_out),
        .zero_out    (zero_out)
`ifdef MCCOY_CARRY_EN
        ,
        .carry_out   (carry_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2:0] LD = 3'd0, ST = 3'd1, LI = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, BEZ = 3'd5, JA = 3'd6, X7 = 3'd7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and returns once it has executed (back in FETCH).
    task automatic issue(input logic [2:0] op, input logic [2:0] a);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout observed=0 expected=1");
        end
        instr       = {a, op};
        instr_valid = 1'b1;
        tick();
        last_acc_cyc = cyc;
        instr_valid = 1'b0;
        instr       = 6'h2A;
        tick();
    endtask

    int t0, t1;

    initial begin
        reset = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_acc", 32'(acc_out), 0);
        chk("rst_zero", 32'(zero_out), 1);
        chk("rst_ready", 32'(instr_ready), 1);
`ifdef MCCOY_CARRY_EN
        chk("rst_carry", 32'(carry_out), 0);
`endif

        // LI 3; ST r1; ADD r1, valid held high across the three
        instr = {3'd3, LI}; instr_valid = 1'b1;
        tick(); t0 = cyc;
        chk("exec_ready_low", 32'(instr_ready), 0);
        tick();
        instr = {3'd1, ST};
        tick(); t1 = cyc;
        chk("accept_gap_st", 32'(t1 - t0), 2);
        tick();
        instr = {3'd1, ADD};
        tick(); t0 = cyc;
        chk("accept_gap_add", 32'(t0 - t1), 2);
        instr_valid = 1'b0;
        tick();
        chk("add_acc", 32'(acc_out), 6);
        chk("add_pc", 32'(pc_out), 3);
        chk("add_zero", 32'(zero_out), 0);

        // idle in FETCH
        for (int i = 0; i < 5; i++) tick();
        chk("idle_pc", 32'(pc_out), 3);
        chk("idle_acc", 32'(acc_out), 6);
        chk("idle_ready", 32'(instr_ready), 1);

        issue(LI, 3'b111);
        chk("li_neg", 32'(acc_out), 63);
        issue(ST, 3'd2);
        issue(LI, 3'd0);
        chk("li0_zero", 32'(zero_out), 1);
        issue(BEZ, 3'd2);
        chk("bez_taken_pc", 32'(pc_out), 63);
        issue(LI, 3'd1);
        chk("pc_wrap", 32'(pc_out), 0);
        issue(BEZ, 3'd2);
        chk("bez_not_taken_pc", 32'(pc_out), 1);

        issue(SUB, 3'd1);
        chk("sub_acc", 32'(acc_out), 62);
        chk("sub_pc", 32'(pc_out), 2);
`ifdef MCCOY_CARRY_EN
        chk("sub_borrow_carry", 32'(carry_out), 0);
`endif
        // AND with 63 keeps 62; BCS with carry clear also leaves acc at 62
        issue(X7, 3'd2);
        chk("op7_acc", 32'(acc_out), 62);
        chk("op7_pc", 32'(pc_out), 3);
        issue(JA, 3'd0);
        chk("ja_pc", 32'(pc_out), 62);
        chk("ja_acc", 32'(acc_out), 62);

        issue(LD, 3'd1);
        chk("ld_acc", 32'(acc_out), 3);
        issue(ST, 3'd3);
        issue(LD, 3'd3);
        chk("st_ld_acc", 32'(acc_out), 3);
        chk("st_ld_pc", 32'(pc_out), 1);

        // reset during EXEC of ADD
        instr = {3'd1, ADD}; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_acc", 32'(acc_out), 0);
        chk("midrst_pc", 32'(pc_out), 0);
        chk("midrst_ready", 32'(instr_ready), 1);
        tick();
        chk("midrst_no_exec_acc", 32'(acc_out), 0);
        issue(LD, 3'd1);
        chk("midrst_regs_cleared", 32'(acc_out), 0);

`ifdef MCCOY_CARRY_EN
        issue(LI, 3'b111);
        issue(ST, 3'd1);
        issue(LI, 3'd1);
        issue(ADD, 3'd1);
        chk("cadd_acc", 32'(acc_out), 0);
        chk("cadd_carry", 32'(carry_out), 1);
        issue(X7, 3'd0);
        chk("bcs_pc", 32'(pc_out), 0);
        chk("bcs_carry_kept", 32'(carry_out), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
